// File: rtl/lcd_bus_controller.sv
// HD44780-style write-only bus sequencer: setup, enable strobe, hold, then execution wait.
// Latency: oDone at t0 + nibbles*(SETUP+EN_HIGH+HOLD) + wait + 1, where t0 is the accept cycle.
// Backpressure: start edges are accepted only in IDLE; edges seen while busy are dropped.
module lcd_bus_controller #(
  parameter int BUS_4BIT      = 0,
  parameter int SETUP_CYC     = 2,
  parameter int EN_HIGH_CYC   = 16,
  parameter int HOLD_CYC      = 2,
  parameter int EXEC_CYC      = 2000,
  parameter int LONG_EXEC_CYC = 82000
) (
  input  logic                                 iCLK,
  input  logic                                 iRST,
  input  logic                                 iStart,
  input  logic                                 iRS,
  input  logic [7:0]                           iDATA,
  output logic                                 oBusy,
  output logic                                 oDone,
  output logic                                 LCD_EN,
  output logic                                 LCD_RS,
  output logic                                 LCD_RW,
  output logic [(BUS_4BIT != 0 ? 4 : 8)-1:0]   LCD_DATA
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXP = max2(max2(max2(SETUP_CYC, EN_HIGH_CYC), max2(HOLD_CYC, EXEC_CYC)),
                             LONG_EXEC_CYC);
  localparam int CW   = $clog2(MAXP + 1);

  // Each phase loads (length - 1) on entry and leaves when the counter reaches zero.
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LD    = CW'(EN_HIGH_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYC - 1);
  localparam logic [CW-1:0] LONG_LD  = CW'(LONG_EXEC_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          nib, nib_nxt;      // 1 while sending the low nibble on a 4-bit bus
  logic          start_q;
  logic          rs_q;
  logic [7:0]    dat_q;
  logic          start_edge;
  logic          accept;
  logic          long_wait;
  logic          drive;

  assign start_edge = iStart & ~start_q;

  // Clear-display (0x01) and return-home (0x02/0x03) commands need the long execution wait.
  assign long_wait = ~rs_q & ((dat_q[7:1] == 7'b0000_001) | (dat_q == 8'h01));

  // State, counter, nibble flag, start history and transfer latches.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= IDLE;
      cnt     <= '0;
      nib     <= 1'b0;
      start_q <= 1'b0;
      rs_q    <= 1'b0;
      dat_q   <= 8'h00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      nib     <= nib_nxt;
      start_q <= iStart;
      if (accept) begin
        rs_q  <= iRS;
        dat_q <= iDATA;
      end
    end
  end

  // Next-state and counter reload; every transition reloads the counter for the new phase.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    nib_nxt   = nib;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_nxt = SETUP;
          cnt_nxt   = SETUP_LD;
          nib_nxt   = 1'b0;
          accept    = 1'b1;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = PULSE;
          cnt_nxt   = EN_LD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          if ((BUS_4BIT != 0) && !nib) begin
            state_nxt = SETUP;
            cnt_nxt   = SETUP_LD;
            nib_nxt   = 1'b1;
          end else begin
            state_nxt = EXEC;
            cnt_nxt   = long_wait ? LONG_LD : EXEC_LD;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Moore outputs decoded from state so reset forces them low on the same edge.
  always_comb begin
    drive  = (state == SETUP) | (state == PULSE) | (state == HOLD);
    oBusy  = (state != IDLE);
    oDone  = (state == DONE);
    LCD_EN = (state == PULSE);
    LCD_RS = drive & rs_q;
    LCD_RW = 1'b0;
  end

  if (BUS_4BIT != 0) begin : g_bus4
    assign LCD_DATA = drive ? (nib ? dat_q[3:0] : dat_q[7:4]) : 4'h0;
  end else begin : g_bus8
    assign LCD_DATA = drive ? dat_q : 8'h00;
  end

endmodule

// File: doc/lcd_bus_controller.md
LCD_BUS_CONTROLLER -- requirements
Module: lcd_bus_controller

Interface
REQ-001 SHALL have parameter BUS_4BIT, default 0, where 0 selects an 8-bit HD44780 bus and 1 selects a 4-bit bus.
REQ-002 SHALL have parameter SETUP_CYC, default 2, giving iCLK cycles of RS/data setup before LCD_EN rises; legal range 1 or more.
REQ-003 SHALL have parameter EN_HIGH_CYC, default 16, giving iCLK cycles LCD_EN is high per nibble or byte; legal range 1 or more.
REQ-004 SHALL have parameter HOLD_CYC, default 2, giving iCLK cycles RS/data are held after LCD_EN falls; legal range 1 or more.
REQ-005 SHALL have parameter EXEC_CYC, default 2000, giving the command execution wait in iCLK cycles (40 us at 50 MHz); legal range 1 or more.
REQ-006 SHALL have parameter LONG_EXEC_CYC, default 82000, giving the execution wait for clear/home (1.64 ms at 50 MHz); legal range EXEC_CYC or more.
REQ-007 SHALL have port iCLK, input, width 1: the single clock; all logic is clocked on the rising edge.
REQ-008 SHALL have port iRST, input, width 1: synchronous, active-high reset.
REQ-009 SHALL have port iStart, input, width 1: transfer request, acted on at its rising edge.
REQ-010 SHALL have port iRS, input, width 1: register select, 0 = command, 1 = data; sampled on accept.
REQ-011 SHALL have port iDATA, input, width 8: byte to transfer; sampled on accept.
REQ-012 SHALL have port oBusy, input-independent output, width 1: high while a transfer is in progress.
REQ-013 SHALL have port oDone, output, width 1: one-cycle completion pulse.
REQ-014 SHALL have port LCD_EN, output, width 1: panel enable strobe.
REQ-015 SHALL have port LCD_RS, output, width 1: panel register select.
REQ-016 SHALL have port LCD_RW, output, width 1: constant 0 (write only).
REQ-017 SHALL have port LCD_DATA, output, width 8 if BUS_4BIT=0, else 4: panel data bus.

Function
REQ-018 SHALL register iStart every cycle and detect a rising edge as {previous,current}=01.
REQ-019 SHALL accept a rising edge only in state IDLE; the accept cycle is t0. iRS and iDATA SHALL be latched at t0.
REQ-020 SHALL silently ignore edges occurring in any other state; they SHALL NOT be queued.
REQ-021 SHALL implement the states IDLE, SETUP, PULSE, HOLD, EXEC and DONE.
REQ-022 IDLE->SETUP at accept; SETUP (SETUP_CYC cycles)->PULSE (EN_HIGH_CYC cycles)->HOLD (HOLD_CYC cycles).
REQ-023 HOLD SHALL exit to SETUP for the second nibble when BUS_4BIT=1 and the first nibble is done; otherwise it SHALL exit to EXEC.
REQ-024 EXEC SHALL wait for the selected execution count, then go to DONE for one cycle, then return to IDLE.
REQ-025 LCD_RS and LCD_DATA SHALL be driven from the latched values from t0+1 through the final HOLD cycle; they SHALL be stable while LCD_EN is high.
REQ-026 LCD_EN SHALL be high exactly during PULSE cycles and low in every other state.
REQ-027 In 4-bit mode, LCD_DATA SHALL carry latched bits [7:4] for the first nibble and bits [3:0] for the second.
REQ-028 The long wait (LONG_EXEC_CYC) SHALL be used when the latched iRS=0 and the latched data matches 0000_001x or equals 0000_0001; all other transfers SHALL use EXEC_CYC.
REQ-029 oBusy SHALL be high from t0+1 through the DONE cycle inclusive, and low in IDLE.
REQ-030 oDone SHALL be high only in DONE, for exactly one cycle.
REQ-031 The single down-counter SHALL be sized as ceil(log2(max of all parameters + 1)) bits, SHALL never wrap, and SHALL reload on every state entry.
REQ-032 8-bit mode latency SHALL be: oDone at t0 + SETUP_CYC + EN_HIGH_CYC + HOLD_CYC + wait + 1.
REQ-033 4-bit mode latency SHALL add SETUP_CYC + EN_HIGH_CYC + HOLD_CYC to the 8-bit latency.

Reset
REQ-034 While iRST is high at a clock edge, the state SHALL become IDLE; oBusy, oDone, LCD_EN, LCD_RS and LCD_RW SHALL be 0; LCD_DATA SHALL be 0; the counter, latches and iStart history SHALL be 0.
REQ-035 Reset mid-transfer SHALL abandon the transfer with no oDone; LCD_EN SHALL fall on that edge.
REQ-036 If iStart is held high across the release of reset, an edge SHALL be detected and accepted on the first cycle after release.

Verification
Bench parameters: SETUP=2, EN_HIGH=4, HOLD=2, EXEC=10, LONG=50.
REQ-037 8-bit, iRS=1, iDATA=0x41, edge at t0 -> LCD_DATA=0x41 and LCD_RS=1 over t0+1..t0+8; LCD_EN high over t0+3..t0+6; oDone high only at t0+19.
REQ-038 8-bit, iRS=0, iDATA=0x01 -> LCD_EN high over t0+3..t0+6; oDone at t0+59; oBusy high over t0+1..t0+59.
REQ-039 BUS_4BIT=1, iRS=1, iDATA=0xA5 -> LCD_DATA=0xA with LCD_EN high over t0+3..t0+6; LCD_DATA=0x5 with LCD_EN high over t0+11..t0+14; oDone at t0+27.
REQ-040 Second iStart edge at t0+5 during a transfer -> ignored; exactly one LCD_EN pulse and one oDone; a new edge at t0+20 is accepted.
REQ-041 iRST asserted at t0+4 (LCD_EN high) -> LCD_EN=0, oBusy=0 after that edge; no oDone; the next edge behaves as in REQ-037.
REQ-042 iRS=0, iDATA=0x03 -> long wait, oDone at t0+59; iRS=1, iDATA=0x01 -> short wait, oDone at t0+19.
